ysyx_mem_arbiter: RTL and testbench

- Two-master, one-slave arbiter sharing the single memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle ysyx core.
- Only one transaction is outstanding at a time.
- Round-robin arbitration prevents starvation.
- A response watchdog returns an error to the owner if the slave never answers.

---
 rtl/ysyx_mem_arbiter_pkg.sv | 21 ++
 rtl/ysyx_rr_arb2.sv | 28 ++
 rtl/ysyx_mem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter.
// Holds the FSM state encoding, master IDs, the default response timeout and
// the watchdog width.
package ysyx_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbReq  = 2'd1,
    ArbResp = 2'd2,
    ArbDone = 2'd3
  } arb_state_e;

  localparam logic ArbMIfu = 1'b0;
  localparam logic ArbMLsu = 1'b1;

  localparam int unsigned ArbTimeoutDefault = 255;

  // Wide enough for TIMEOUT up to 65535; never wraps because expiry fires at TIMEOUT-1.
  localparam int unsigned ArbWdW = 16;

endpackage

// File: rtl/ysyx_rr_arb2.sv
// Combinational two-way round-robin grant.
// Ports:
//   valid_i[1:0]  request valids, bit 0 = IFU, bit 1 = LSU
//   last_grant_i  master granted most recently
//   gnt_valid_o   some master is granted
//   gnt_id_o      granted master ID
module ysyx_rr_arb2
  import ysyx_mem_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  always_comb begin
    gnt_valid_o = |valid_i;
    gnt_id_o    = ArbMIfu;
    case (valid_i)
      2'b01:   gnt_id_o = ArbMIfu;
      2'b10:   gnt_id_o = ArbMLsu;
      // Tie: whoever did not win last time.
      2'b11:   gnt_id_o = ~last_grant_i;
      default: gnt_id_o = ArbMIfu;
    endcase
  end

endmodule

// File: rtl/ysyx_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter, one transaction outstanding.
// Round-robin arbitration in IDLE, request held to the slave in REQ, response
// (or watchdog timeout) collected in RESP, one-cycle response pulse in DONE.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   ifu_req_* / ifu_rsp_*  instruction-fetch master (read only)
//   lsu_req_* / lsu_rsp_*  load/store master
//   mem_req_* / mem_rsp_*  shared slave port
module ysyx_mem_arbiter
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = ArbTimeoutDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  ifu_req_valid_i,
  input  logic [ADDR_W-1:0]     ifu_req_addr_i,
  output logic                  ifu_req_ready_o,
  output logic                  ifu_rsp_valid_o,
  output logic [DATA_W-1:0]     ifu_rsp_rdata_o,
  output logic                  ifu_rsp_err_o,

  input  logic                  lsu_req_valid_i,
  input  logic [ADDR_W-1:0]     lsu_req_addr_i,
  input  logic                  lsu_req_wen_i,
  input  logic [DATA_W-1:0]     lsu_req_wdata_i,
  input  logic [DATA_W/8-1:0]   lsu_req_wmask_i,
  output logic                  lsu_req_ready_o,
  output logic                  lsu_rsp_valid_o,
  output logic [DATA_W-1:0]     lsu_rsp_rdata_o,
  output logic                  lsu_rsp_err_o,

  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_W-1:0]     mem_req_addr_o,
  output logic                  mem_req_wen_o,
  output logic [DATA_W-1:0]     mem_req_wdata_o,
  output logic [DATA_W/8-1:0]   mem_req_wmask_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_W-1:0]     mem_rsp_rdata_i
);

  localparam logic [ArbWdW-1:0] WdLast = ArbWdW'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [ArbWdW-1:0]     wd_q, wd_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wmask_q, wmask_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic [DATA_W-1:0]     ifu_rdata_q, ifu_rdata_d;
  logic                  ifu_err_q, ifu_err_d;
  logic                  lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic [DATA_W-1:0]     lsu_rdata_q, lsu_rdata_d;
  logic                  lsu_err_q, lsu_err_d;

  logic                  gnt_valid;
  logic                  gnt_id;
  logic                  grant;
  logic                  rsp_fire;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  ysyx_rr_arb2 u_rr_arb2 (
    .valid_i      ({lsu_req_valid_i, ifu_req_valid_i}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  assign grant = (state_q == ArbIdle) && gnt_valid;

  // Gated with reset so the readys are 0 while reset is held even if a master is requesting.
  assign ifu_req_ready_o = rst_ni && grant && (gnt_id == ArbMIfu);
  assign lsu_req_ready_o = rst_ni && grant && (gnt_id == ArbMLsu);

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    wd_d            = wd_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    mem_req_valid_d = mem_req_valid_q;
    ifu_rsp_valid_d = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    ifu_err_d       = ifu_err_q;
    lsu_rsp_valid_d = 1'b0;
    lsu_rdata_d     = lsu_rdata_q;
    lsu_err_d       = lsu_err_q;
    rsp_fire        = 1'b0;
    rsp_rdata       = '0;
    rsp_err         = 1'b0;

    unique case (state_q)
      ArbIdle: begin
        if (grant) begin
          addr_d          = (gnt_id == ArbMLsu) ? lsu_req_addr_i : ifu_req_addr_i;
          wen_d           = (gnt_id == ArbMLsu) && lsu_req_wen_i;
          wdata_d         = (gnt_id == ArbMLsu) ? lsu_req_wdata_i : '0;
          wmask_d         = (gnt_id == ArbMLsu) ? lsu_req_wmask_i : '0;
          owner_d         = gnt_id;
          last_grant_d    = gnt_id;
          mem_req_valid_d = 1'b1;
          state_d         = ArbReq;
        end
      end
      ArbReq: begin
        // A response in the handshake cycle is not looked at here.
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          wd_d            = '0;
          state_d         = ArbResp;
        end
      end
      ArbResp: begin
        // A real response beats an expiring watchdog in the same cycle.
        if (mem_rsp_valid_i) begin
          rsp_fire  = 1'b1;
          rsp_rdata = wen_q ? '0 : mem_rsp_rdata_i;
        end else if (wd_q == WdLast) begin
          rsp_fire  = 1'b1;
          rsp_err   = 1'b1;
        end else begin
          wd_d = wd_q + ArbWdW'(1);
        end
        if (rsp_fire) begin
          state_d = ArbDone;
          if (owner_q == ArbMLsu) begin
            lsu_rsp_valid_d = 1'b1;
            lsu_rdata_d     = rsp_rdata;
            lsu_err_d       = rsp_err;
          end else begin
            ifu_rsp_valid_d = 1'b1;
            ifu_rdata_d     = rsp_rdata;
            ifu_err_d       = rsp_err;
          end
        end
      end
      ArbDone: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ArbIdle;
      last_grant_q    <= ArbMLsu;
      owner_q         <= ArbMIfu;
      wd_q            <= '0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      mem_req_valid_q <= 1'b0;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rdata_q     <= '0;
      ifu_err_q       <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      lsu_rdata_q     <= '0;
      lsu_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      wd_q            <= wd_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      wmask_q         <= wmask_d;
      mem_req_valid_q <= mem_req_valid_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      ifu_rdata_q     <= ifu_rdata_d;
      ifu_err_q       <= ifu_err_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      lsu_rdata_q     <= lsu_rdata_d;
      lsu_err_q       <= lsu_err_d;
    end
  end

  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wen_o   = wen_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_wmask_o = wmask_q;

  assign ifu_rsp_valid_o = ifu_rsp_valid_q;
  assign ifu_rsp_rdata_o = ifu_rdata_q;
  assign ifu_rsp_err_o   = ifu_err_q;
  assign lsu_rsp_valid_o = lsu_rsp_valid_q;
  assign lsu_rsp_rdata_o = lsu_rdata_q;
  assign lsu_rsp_err_o   = lsu_err_q;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Self-checking bench for ysyx_mem_arbiter: a directed table, hand-written
// tie/reset sequences and randomized transactions against a transaction-level model.
module tb_ysyx_mem_arbiter;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ifu_req_valid_i;
  logic [63:0] ifu_req_addr_i;
  logic        ifu_req_ready_o;
  logic        ifu_rsp_valid_o;
  logic [63:0] ifu_rsp_rdata_o;
  logic        ifu_rsp_err_o;
  logic        lsu_req_valid_i;
  logic [63:0] lsu_req_addr_i;
  logic        lsu_req_wen_i;
  logic [63:0] lsu_req_wdata_i;
  logic [7:0]  lsu_req_wmask_i;
  logic        lsu_req_ready_o;
  logic        lsu_rsp_valid_o;
  logic [63:0] lsu_rsp_rdata_o;
  logic        lsu_rsp_err_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_req_wen_o;
  logic [63:0] mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rsp_rdata_i;

  int total = 0;
  int bad   = 0;
  bit last_lsu;  // model: master granted most recently

  always #5 clk_i = ~clk_i;

  ysyx_mem_arbiter #(
    .ADDR_W  (64),
    .DATA_W  (64),
    .TIMEOUT (TO)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .ifu_req_valid_i (ifu_req_valid_i),
    .ifu_req_addr_i  (ifu_req_addr_i),
    .ifu_req_ready_o (ifu_req_ready_o),
    .ifu_rsp_valid_o (ifu_rsp_valid_o),
    .ifu_rsp_rdata_o (ifu_rsp_rdata_o),
    .ifu_rsp_err_o   (ifu_rsp_err_o),
    .lsu_req_valid_i (lsu_req_valid_i),
    .lsu_req_addr_i  (lsu_req_addr_i),
    .lsu_req_wen_i   (lsu_req_wen_i),
    .lsu_req_wdata_i (lsu_req_wdata_i),
    .lsu_req_wmask_i (lsu_req_wmask_i),
    .lsu_req_ready_o (lsu_req_ready_o),
    .lsu_rsp_valid_o (lsu_rsp_valid_o),
    .lsu_rsp_rdata_o (lsu_rsp_rdata_o),
    .lsu_rsp_err_o   (lsu_rsp_err_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wen_o   (mem_req_wen_o),
    .mem_req_wdata_o (mem_req_wdata_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_rdata_i (mem_rsp_rdata_i)
  );

  typedef struct {
    logic        iv;
    logic        lv;
    logic        wen;
    logic [63:0] iaddr;
    logic [63:0] laddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          req_wait;   // cycles mem_req_ready is held low
    int          rsp_wait;   // RESP cycle index of the answer; >= TO means no answer in time
    logic [63:0] sdata;
    logic        stray;      // slave raises mem_rsp_valid in the handshake cycle
    logic        exp_lsu;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;    // cycles from grant edge to rsp_valid
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model, transaction level.
  function automatic bit pick(input bit iv, input bit lv, input bit last);
    if (iv && lv) return !last;
    return lv;
  endfunction

  function automatic int model_lat(input int rw, input int rsw);
    int n;
    n = (rsw < TO) ? rsw + 1 : TO;
    return 2 + rw + n;
  endfunction

  function automatic logic [63:0] model_rdata(input bit lsu, input bit wen, input int rsw,
                                              input logic [63:0] sd);
    if (rsw >= TO) return 64'h0;
    if (lsu && wen) return 64'h0;
    return sd;
  endfunction

  // Entered just after a posedge with the requests for this IDLE cycle driven.
  task automatic serve(input int req_wait, input int rsp_wait, input logic [63:0] sdata,
                       input bit stray, input bit exp_lsu, input logic [63:0] exp_rdata,
                       input bit exp_err, input int exp_lat);
    int          lat;
    int          k;
    bit          got;
    logic [63:0] e_addr;
    logic        e_wen;
    logic [7:0]  e_mask;
    e_addr = exp_lsu ? lsu_req_addr_i : ifu_req_addr_i;
    e_wen  = exp_lsu & lsu_req_wen_i;
    e_mask = exp_lsu ? lsu_req_wmask_i : 8'h00;
    @(negedge clk_i);
    chk("grant_ifu_ready", ifu_req_ready_o, !exp_lsu);
    chk("grant_lsu_ready", lsu_req_ready_o, exp_lsu);
    chk("idle_rsp_quiet", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 64'h0);
    chk("idle_mem_valid", mem_req_valid_o, 64'h0);
    @(posedge clk_i); #1;
    lat = 1;
    if (exp_lsu) lsu_req_valid_i = 1'b0;
    else ifu_req_valid_i = 1'b0;
    for (int i = 0; i <= req_wait; i++) begin
      mem_req_ready_i = (i == req_wait);
      mem_rsp_valid_i = stray && (i == req_wait);
      mem_rsp_rdata_i = ~sdata;
      @(negedge clk_i);
      chk("req_valid", mem_req_valid_o, 64'h1);
      chk("req_addr", mem_req_addr_o, e_addr);
      chk("req_wen", mem_req_wen_o, e_wen);
      chk("req_wmask", mem_req_wmask_o, e_mask);
      if (exp_lsu) chk("req_wdata", mem_req_wdata_o, lsu_req_wdata_i);
      chk("req_readys_low", {ifu_req_ready_o, lsu_req_ready_o}, 64'h0);
      @(posedge clk_i); #1;
      lat++;
    end
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    k   = 0;
    got = 1'b0;
    while (!got && k < 64) begin
      mem_rsp_valid_i = (k == rsp_wait);
      mem_rsp_rdata_i = (k == rsp_wait) ? sdata : ~sdata;
      @(negedge clk_i);
      if ((exp_lsu ? lsu_rsp_valid_o : ifu_rsp_valid_o) === 1'b1) begin
        got = 1'b1;
      end else begin
        chk("resp_mem_valid_low", mem_req_valid_o, 64'h0);
        @(posedge clk_i); #1;
        lat++;
        k++;
      end
    end
    chk("rsp_seen", got, 64'h1);
    if (got) begin
      chk("rsp_other_quiet", exp_lsu ? ifu_rsp_valid_o : lsu_rsp_valid_o, 64'h0);
      chk("rsp_rdata", exp_lsu ? lsu_rsp_rdata_o : ifu_rsp_rdata_o, exp_rdata);
      chk("rsp_err", exp_lsu ? lsu_rsp_err_o : ifu_rsp_err_o, exp_err);
      chk("rsp_latency", lat, exp_lat);
    end
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got=running want=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int  r;
    int  rw;
    int  rsw;
    int  pulses;
    bit  first;
    logic [63:0] sd;

    rst_ni          = 1'b0;
    ifu_req_valid_i = 1'b0;
    ifu_req_addr_i  = 64'h0;
    lsu_req_valid_i = 1'b0;
    lsu_req_addr_i  = 64'h0;
    lsu_req_wen_i   = 1'b0;
    lsu_req_wdata_i = 64'h0;
    lsu_req_wmask_i = 8'h0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_rdata_i = 64'h0;
    last_lsu        = 1'b1;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'h0, 64'h0, 8'h00, 0, 0,
               64'h0000_0413_0000_0297, 1'b0, 1'b0, 64'h0000_0413_0000_0297, 1'b0, 3};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_BABE, 8'h0F, 3, 0,
               64'h1234, 1'b0, 1'b1, 64'h0, 1'b0, 6};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_2000, 64'h0, 8'hFF, 0, 4,
               64'h55, 1'b0, 1'b1, 64'h0, 1'b1, 6};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 64'h8000_0004, 64'h0, 64'h0, 8'h00, 0, 1,
               64'h1111_2222_3333_4444, 1'b1, 1'b0, 64'h1111_2222_3333_4444, 1'b0, 4};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h8000_3008, 64'h0, 8'hFF, 1, 3,
               64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 1'b1, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 7};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 64'h8000_0010, 64'h0, 64'h0, 8'h00, 2, 2,
               64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 64'hFFFF_0000_FFFF_0000, 1'b0, 7};

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_valid", mem_req_valid_o, 64'h0);
    chk("rst_mem_addr", mem_req_addr_o, 64'h0);
    chk("rst_mem_wmask", mem_req_wmask_o, 64'h0);
    chk("rst_rsp_valids", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 64'h0);
    chk("rst_readys", {ifu_req_ready_o, lsu_req_ready_o}, 64'h0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Tie right after reset, both masters keep requesting: IFU, LSU, IFU, LSU.
    lsu_req_addr_i = 64'h8000_4000;
    ifu_req_addr_i = 64'h8000_0100;
    for (int i = 0; i < 4; i++) begin
      ifu_req_valid_i = 1'b1;
      lsu_req_valid_i = 1'b1;
      serve(0, 0, 64'h100 + 64'(i), 1'b0, (i % 2) == 1, 64'h100 + 64'(i), 1'b0, 3);
      last_lsu = (i % 2) == 1;
    end

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      ifu_req_valid_i = tbl[i].iv;
      lsu_req_valid_i = tbl[i].lv;
      ifu_req_addr_i  = tbl[i].iaddr;
      lsu_req_addr_i  = tbl[i].laddr;
      lsu_req_wen_i   = tbl[i].wen;
      lsu_req_wdata_i = tbl[i].wdata;
      lsu_req_wmask_i = tbl[i].wmask;
      serve(tbl[i].req_wait, tbl[i].rsp_wait, tbl[i].sdata, tbl[i].stray, tbl[i].exp_lsu,
            tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
      last_lsu = tbl[i].exp_lsu;
    end

    // Randomized transactions against the model.
    for (int it = 0; it < 40; it++) begin
      r               = $urandom_range(1, 3);
      ifu_req_valid_i = r[0];
      lsu_req_valid_i = r[1];
      ifu_req_addr_i  = {$urandom, $urandom};
      lsu_req_addr_i  = {$urandom, $urandom};
      lsu_req_wen_i   = 1'($urandom_range(0, 1));
      lsu_req_wdata_i = {$urandom, $urandom};
      lsu_req_wmask_i = 8'($urandom);
      rw  = $urandom_range(0, 3);
      rsw = $urandom_range(0, TO);
      sd  = {$urandom, $urandom};
      first = pick(r[0], r[1], last_lsu);
      serve(rw, rsw, sd, 1'($urandom_range(0, 1)), first,
            model_rdata(first, lsu_req_wen_i, rsw, sd), rsw >= TO, model_lat(rw, rsw));
      last_lsu = first;
      if (r[0] && r[1]) begin
        // Loser kept requesting; it is served next.
        rsw = $urandom_range(0, TO);
        sd  = sd ^ 64'h1;
        first = pick(ifu_req_valid_i, lsu_req_valid_i, last_lsu);
        serve(rw, rsw, sd, 1'b0, first,
              model_rdata(first, lsu_req_wen_i, rsw, sd), rsw >= TO, model_lat(rw, rsw));
        last_lsu = first;
      end
    end

    // Reset in the middle of RESP with a nonzero response already latched.
    ifu_req_valid_i = 1'b1;
    ifu_req_addr_i  = 64'h8000_0200;
    @(negedge clk_i);
    chk("mid_grant_ifu", ifu_req_ready_o, 64'h1);
    @(posedge clk_i); #1;
    ifu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_req_ready_i = 1'b0;
    lsu_req_valid_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_mem_valid", mem_req_valid_o, 64'h0);
    chk("arst_mem_addr", mem_req_addr_o, 64'h0);
    chk("arst_mem_wdata", mem_req_wdata_o, 64'h0);
    chk("arst_readys", {ifu_req_ready_o, lsu_req_ready_o}, 64'h0);
    chk("arst_rsp_valids", {ifu_rsp_valid_o, lsu_rsp_valid_o}, 64'h0);
    chk("arst_ifu_rdata", ifu_rsp_rdata_o, 64'h0);
    chk("arst_lsu_rdata", lsu_rsp_rdata_o, 64'h0);
    chk("arst_errs", {ifu_rsp_err_o, lsu_rsp_err_o}, 64'h0);
    repeat (2) @(posedge clk_i);
    #1;
    lsu_req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (ifu_rsp_valid_o || lsu_rsp_valid_o || mem_req_valid_o) pulses++;
    end
    chk("post_rst_no_activity", pulses, 64'h0);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    last_lsu        = 1'b1;
    ifu_req_valid_i = 1'b1;
    lsu_req_valid_i = 1'b1;
    lsu_req_wen_i   = 1'b0;
    serve(0, 0, 64'h77, 1'b0, 1'b0, 64'h77, 1'b0, 3);
    serve(0, 1, 64'h88, 1'b0, 1'b1, 64'h88, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
